irq_pending_latch: RTL and testbench
====================================

IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-low: clk (input, 1, rising-edge clock) and rst_n (input, 1, synchronous active-low reset).
REQ-002 The block SHALL have the port enable (input, 1): permits a new issue from IDLE.
REQ-003 The block SHALL have the port clear (input, 1): synchronous flush of pending, overflow and FSM.
REQ-004 The block SHALL have the port req (input, 8): level request lines; bit 0 is highest priority, bit 7 is lowest.
REQ-005 The block SHALL have the port mask_we (input, 1): mask register write strobe.
REQ-006 The block SHALL have the port mask_wdata (input, 8): new mask value; 1 = source masked.
REQ-007 The block SHALL have the port irq_ack (input, 1): consumer accepts the presented code.
REQ-008 The block SHALL have the port irq_valid (output, 1): a code is presented.
REQ-009 The block SHALL have the port irq_code (output, 3): index of the presented source.
REQ-010 The block SHALL have the port irq_onehot (output, 8): one-hot of irq_code, all-zero when irq_valid = 0; this is the input of the downstream 8-to-3 encoder.
REQ-011 The block SHALL have the ports pending (output, 8) and overflow (output, 8): status registers.

Function
REQ-012 An edge SHALL be defined as req[i]=1 with the registered previous sample req_q[i]=0; req_q updates every cycle.
REQ-013 An edge on bit i SHALL set pending[i] at that clock edge, regardless of mask or enable.
REQ-014 An edge on bit i while pending[i] is already 1 SHALL set overflow[i], which is sticky until clear or reset.
REQ-015 The FSM SHALL have exactly two states: IDLE and ISSUE.
REQ-016 In IDLE with enable=1 and (pending & ~mask) != 0, the FSM SHALL latch the lowest set index of (pending & ~mask) into irq_code and move to ISSUE.
REQ-017 irq_valid SHALL be 1 exactly while the FSM is in ISSUE.
REQ-018 Latency: a req rise sampled at edge E1 SHALL give pending=1 after E1 and irq_valid=1 after E2.
REQ-019 irq_code and irq_onehot SHALL hold stable throughout ISSUE, even if a higher-priority request arrives or the source becomes masked.
REQ-020 In ISSUE with irq_ack=1, the block SHALL clear pending[irq_code] and return to IDLE, so there is one idle cycle between consecutive issues.
REQ-021 irq_ack while in IDLE SHALL be ignored.
REQ-022 A new edge on bit i in the same cycle as the ack-clear of bit i: the set SHALL win, leaving pending[i]=1, with no overflow.
REQ-023 mask_we SHALL load the mask at the clock edge; the new mask affects selection from the next cycle only.
REQ-024 enable=0 SHALL block only the IDLE->ISSUE transition; an in-progress ISSUE completes normally.
REQ-025 clear=1 SHALL zero pending and overflow, force IDLE and drop irq_valid at the next edge; it takes priority over edges and ack in the same cycle.
REQ-026 clear SHALL leave mask and req_q unchanged.

Reset
REQ-027 With rst_n=0 at a clock edge: pending=0, overflow=0, req_q=0, mask=8'hFF, FSM=IDLE, irq_code=0, irq_valid=0, irq_onehot=0.
REQ-028 A req bit already high at reset release SHALL count as an edge on the first active cycle.
REQ-029 Reset SHALL take priority over clear and all other inputs.

Structure
REQ-030 Package irq_pkg SHALL hold NUM_SRC=8, CODE_W=3 and the FSM state enum (IDLE, ISSUE).
REQ-031 The edge detection plus pending/overflow bookkeeping SHALL be a single sub-module, irq_edge_detect; the top level holds the mask, the FSM and the lowest-index select.

Verification
REQ-032 Reset, write mask=8'h00, pulse req=8'h10 -> pending=8'h10 after E1, irq_valid=1 and irq_code=4, irq_onehot=8'h10 after E2; ack -> pending=0, valid=0.
REQ-033 req=8'h81 rising together, mask=0 -> issues code 0 first; after ack and one idle cycle, issues code 7.
REQ-034 While in ISSUE with code 5, raise req[1] -> code stays 5 until ack; code 1 is issued next.
REQ-035 mask=8'h04, edge on bit 2 -> pending=8'h04, no issue; write mask=0 -> irq_valid=1 with code 2 two cycles after mask_we.
REQ-036 Two edges on bit 3 with no ack -> overflow=8'h08; clear -> pending=0, overflow=0, irq_valid=0, mask unchanged.
REQ-037 Ack-clear of bit 6 in the same cycle as a new edge on bit 6 -> pending[6]=1 afterwards, overflow[6]=0; the source is reissued.

Source files
------------

// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared constants, FSM state type and small helper functions for the
// interrupt pending latch.
//   NUM_SRC      : number of request lines handled by the latch
//   CODE_W       : width of the encoded source index
//   irqState_e   : two-state issue FSM (IDLE, ISSUE)
//   lowestIndex  : index of the lowest set bit (bit 0 has highest priority)
//   codeToOnehot : expands a source index into a one-hot vector
// ---------------------------------------------------------------------------
package irq_pkg;

  localparam int NUM_SRC = 8;
  localparam int CODE_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } irqState_e;

  // Walk from the lowest-priority end downwards so that the last hit,
  // which is the lowest set index, is the one that survives.
  function automatic logic [CODE_W-1:0] lowestIndex(input logic [NUM_SRC-1:0] vec);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = CODE_W'(i);
      end
    end
    return idx;
  endfunction

  // Expands an encoded index into a one-hot vector.
  function automatic logic [NUM_SRC-1:0] codeToOnehot(input logic [CODE_W-1:0] code);
    logic [NUM_SRC-1:0] vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// ---------------------------------------------------------------------------
// irq_edge_detect
// Rising-edge detection on the request lines plus the pending and overflow
// status bookkeeping.
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   clear_i    : synchronous flush of pending and overflow
//   req_i      : level request lines
//   ackClr_i   : one-hot of the source being acknowledged this cycle
//   pending_o  : sources that have seen an edge and are not yet acknowledged
//   overflow_o : sticky flag, an edge arrived while the source was pending
// ---------------------------------------------------------------------------
module irq_edge_detect
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [NUM_SRC-1:0] ackClr_i,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [NUM_SRC-1:0] overflow_o
);

  logic [NUM_SRC-1:0] req_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] overflow_q;
  logic [NUM_SRC-1:0] overflow_d;
  logic [NUM_SRC-1:0] reqEdge;

  // Next-state for the status registers. A new edge is ORed in after the
  // acknowledge has been removed, so an edge landing on the very cycle its
  // source is acknowledged leaves the bit pending. Overflow only records an
  // edge on a bit that stays pending, which is why the acknowledged bit is
  // excluded. Clear overrides everything.
  always_comb begin
    reqEdge    = req_i & ~req_q;
    pending_d  = (pending_q & ~ackClr_i) | reqEdge;
    overflow_d = overflow_q | (reqEdge & pending_q & ~ackClr_i);
    if (clear_i) begin
      pending_d  = '0;
      overflow_d = '0;
    end
  end

  // Status and previous-sample registers. The previous sample keeps tracking
  // the request lines through a clear so a level held across the clear is not
  // mistaken for a fresh edge. Resetting it to zero makes any line already
  // high at reset release count as an edge on the first active cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q      <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      req_q      <= req_i;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/irq_pending_latch.sv
// ---------------------------------------------------------------------------
// irq_pending_latch
// Latches request edges as pending interrupts and presents them one at a
// time, lowest index first, to a downstream consumer.
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   enable     : permits a new issue from IDLE
//   clear      : synchronous flush of pending, overflow and the FSM
//   req        : level request lines, bit 0 highest priority
//   mask_we    : mask register write strobe
//   mask_wdata : new mask value, 1 = source masked
//   irq_ack    : consumer accepts the presented code
//   irq_valid  : a code is presented
//   irq_code   : index of the presented source
//   irq_onehot : one-hot of irq_code, all-zero while irq_valid is low
//   pending    : pending status register
//   overflow   : sticky overflow status register
// ---------------------------------------------------------------------------
module irq_pending_latch
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic [NUM_SRC-1:0] req,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               irq_ack,
  output logic               irq_valid,
  output logic [CODE_W-1:0]  irq_code,
  output logic [NUM_SRC-1:0] irq_onehot,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overflow
);

  irqState_e          state_q;
  irqState_e          state_d;
  logic [CODE_W-1:0]  code_q;
  logic [CODE_W-1:0]  code_d;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ackClr;

  irq_edge_detect u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .req_i      (req),
    .ackClr_i   (ackClr),
    .pending_o  (pending),
    .overflow_o (overflow)
  );

  // Mask register. Selection reads the registered value, so a write only
  // influences arbitration from the cycle after the strobe. Clear does not
  // touch it; every source starts masked out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '1;
    end else if (mask_we) begin
      mask_q <= mask_wdata;
    end
  end

  // FSM state and the latched code. The code is only reloaded on the
  // IDLE->ISSUE transition, which keeps it frozen for the whole issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // Next-state logic. From IDLE the lowest unmasked pending source is picked
  // when enabled. In ISSUE the acknowledge returns to IDLE and removes the
  // presented source from pending; going through IDLE guarantees one idle
  // cycle between consecutive issues. Clear forces IDLE from either state.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    ackClr   = '0;
    eligible = pending & ~mask_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && (|eligible)) begin
            state_d = ISSUE;
            code_d  = lowestIndex(eligible);
          end
        end
        ISSUE: begin
          if (irq_ack) begin
            state_d = IDLE;
            ackClr  = codeToOnehot(code_q);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded purely from registered state, so the presented code
  // and its one-hot form cannot glitch with the request or mask inputs.
  always_comb begin
    irq_valid  = (state_q == ISSUE);
    irq_code   = code_q;
    irq_onehot = '0;
    if (state_q == ISSUE) begin
      irq_onehot = codeToOnehot(code_q);
    end
  end

endmodule

// File: tb/tb_irq_pending_latch.sv
// ---------------------------------------------------------------------------
// tb_irq_pending_latch
// Directed scoreboard bench for irq_pending_latch. The stimulus process
// queues the expected issue order and the expected status per cycle; a
// monitor process pops and compares them independently.
// ---------------------------------------------------------------------------
module tb_irq_pending_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       clear;
  logic [7:0] req;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       irq_ack;
  logic       irq_valid;
  logic [2:0] irq_code;
  logic [7:0] irq_onehot;
  logic [7:0] pending;
  logic [7:0] overflow;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  pend;
    logic [7:0]  ovf;
    logic        valid;
    logic        chkCode;
    logic [2:0]  code;
  } statusExp_t;

  statusExp_t  statusQ[$];
  logic [2:0]  issueQ[$];
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  bit          done  = 1'b0;

  irq_pending_latch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .clear      (clear),
    .req        (req),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_ack    (irq_ack),
    .irq_valid  (irq_valid),
    .irq_code   (irq_code),
    .irq_onehot (irq_onehot),
    .pending    (pending),
    .overflow   (overflow)
  );

  // Free-running clock and cycle stamp shared by stimulus and monitor.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle worth of inputs and lets the clock edge sample them.
  task automatic applyStimulus(input logic [7:0] reqV, input logic ackV, input logic clrV,
                               input logic enV, input logic weV, input logic [7:0] wdV);
    req        = reqV;
    irq_ack    = ackV;
    clear      = clrV;
    enable     = enV;
    mask_we    = weV;
    mask_wdata = wdV;
    tick();
  endtask

  // Queues the status expected in the current cycle; code < 0 skips the code.
  task automatic expectStatus(input logic [7:0] pendV, input logic [7:0] ovfV,
                              input logic validV, input int code);
    statusExp_t e;
    e.cyc     = cyc;
    e.pend    = pendV;
    e.ovf     = ovfV;
    e.valid   = validV;
    e.chkCode = (code >= 0);
    e.code    = (code >= 0) ? code[2:0] : 3'd0;
    statusQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: tracks each new issue against the queued order, checks that the
  // presented code stays frozen, and compares the per-cycle status entries.
  initial begin : monitor
    logic [2:0]  curExp;
    logic        wasValid;
    statusExp_t  e;
    curExp   = 3'd0;
    wasValid = 1'b0;
    forever begin
      @(negedge clk);
      if (irq_valid === 1'b1 && !wasValid) begin
        total++;
        if (issueQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL issue_order: got unexpected code %0d expected no issue", irq_code);
        end else begin
          curExp = issueQ.pop_front();
          checkOutput("issue_code", {5'd0, irq_code}, {5'd0, curExp});
          checkOutput("issue_onehot", irq_onehot, 8'd1 << curExp);
        end
      end else if (irq_valid === 1'b1) begin
        checkOutput("hold_code", {5'd0, irq_code}, {5'd0, curExp});
        checkOutput("hold_onehot", irq_onehot, 8'd1 << curExp);
      end else begin
        checkOutput("idle_onehot", irq_onehot, 8'h00);
      end
      wasValid = (irq_valid === 1'b1);

      while (statusQ.size() > 0 && statusQ[0].cyc <= cyc) begin
        e = statusQ.pop_front();
        checkOutput("pending", pending, e.pend);
        checkOutput("overflow", overflow, e.ovf);
        checkOutput("irq_valid", {7'd0, irq_valid}, {7'd0, e.valid});
        if (e.chkCode) begin
          checkOutput("irq_code", {5'd0, irq_code}, {5'd0, e.code});
        end
      end

      if (done || cyc > 2000) begin
        if (!done) begin
          total++;
          bad++;
          $display("[TB] FAIL timeout: got cycle %0d expected completion", cyc);
        end
        checkOutput("issues_left", 8'(issueQ.size()), 8'd0);
        checkOutput("status_left", 8'(statusQ.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin : stimulus
    rst_n      = 1'b0;
    req        = 8'h00;
    irq_ack    = 1'b0;
    clear      = 1'b0;
    enable     = 1'b1;
    mask_we    = 1'b0;
    mask_wdata = 8'h00;

    $display("[TB] reset, level high at release, reset mask, clear keeps req_q");
    applyStimulus(8'h01, 0, 0, 1, 0, 8'h00);
    applyStimulus(8'h01, 0, 0, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, 0);
    rst_n = 1'b1;
    applyStimulus(8'h01, 0, 0, 1, 0, 8'h00); expectStatus(8'h01, 8'h00, 0, -1);
    applyStimulus(8'h01, 0, 0, 1, 0, 8'h00); expectStatus(8'h01, 8'h00, 0, -1);
    applyStimulus(8'h01, 0, 1, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);
    applyStimulus(8'h01, 0, 0, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);

    $display("[TB] single source latency");
    applyStimulus(8'h00, 0, 0, 1, 1, 8'h00);
    issueQ.push_back(3'd4);
    applyStimulus(8'h10, 0, 0, 1, 0, 8'h00); expectStatus(8'h10, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h10, 8'h00, 1, 4);
    applyStimulus(8'h00, 1, 0, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);

    $display("[TB] priority 0 before 7 with idle gap");
    issueQ.push_back(3'd0);
    issueQ.push_back(3'd7);
    applyStimulus(8'h81, 0, 0, 1, 0, 8'h00); expectStatus(8'h81, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h81, 8'h00, 1, 0);
    applyStimulus(8'h00, 1, 0, 1, 0, 8'h00); expectStatus(8'h80, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h80, 8'h00, 1, 7);
    applyStimulus(8'h00, 1, 0, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);

    $display("[TB] code held while higher priority arrives");
    issueQ.push_back(3'd5);
    applyStimulus(8'h20, 0, 0, 1, 0, 8'h00); expectStatus(8'h20, 8'h00, 0, -1);
    applyStimulus(8'h20, 0, 0, 1, 0, 8'h00); expectStatus(8'h20, 8'h00, 1, 5);
    issueQ.push_back(3'd1);
    applyStimulus(8'h22, 0, 0, 1, 0, 8'h00); expectStatus(8'h22, 8'h00, 1, 5);
    applyStimulus(8'h22, 0, 0, 1, 0, 8'h00); expectStatus(8'h22, 8'h00, 1, 5);
    applyStimulus(8'h22, 1, 0, 1, 0, 8'h00); expectStatus(8'h02, 8'h00, 0, -1);
    applyStimulus(8'h22, 0, 0, 1, 0, 8'h00); expectStatus(8'h02, 8'h00, 1, 1);
    applyStimulus(8'h22, 1, 0, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);

    $display("[TB] enable gating and ack in idle");
    applyStimulus(8'h08, 0, 0, 0, 0, 8'h00); expectStatus(8'h08, 8'h00, 0, -1);
    applyStimulus(8'h08, 1, 0, 0, 0, 8'h00); expectStatus(8'h08, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 0, 0, 8'h00); expectStatus(8'h08, 8'h00, 0, -1);
    issueQ.push_back(3'd3);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h08, 8'h00, 1, 3);
    applyStimulus(8'h00, 0, 0, 0, 0, 8'h00); expectStatus(8'h08, 8'h00, 1, 3);
    applyStimulus(8'h00, 1, 0, 0, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);

    $display("[TB] mask timing");
    applyStimulus(8'h00, 0, 0, 1, 1, 8'h04); expectStatus(8'h00, 8'h00, 0, -1);
    applyStimulus(8'h04, 0, 0, 1, 0, 8'h00); expectStatus(8'h04, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h04, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 1, 8'h00); expectStatus(8'h04, 8'h00, 0, -1);
    issueQ.push_back(3'd2);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h04, 8'h00, 1, 2);
    applyStimulus(8'h00, 0, 0, 1, 1, 8'hFF); expectStatus(8'h04, 8'h00, 1, 2);
    applyStimulus(8'h00, 1, 0, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 1, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);

    $display("[TB] overflow and clear");
    issueQ.push_back(3'd3);
    applyStimulus(8'h08, 0, 0, 1, 0, 8'h00); expectStatus(8'h08, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h08, 8'h00, 1, 3);
    applyStimulus(8'h08, 0, 0, 1, 0, 8'h00); expectStatus(8'h08, 8'h08, 1, 3);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h08, 8'h08, 1, 3);
    applyStimulus(8'h08, 1, 1, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);
    applyStimulus(8'h08, 0, 0, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);
    issueQ.push_back(3'd0);
    applyStimulus(8'h01, 0, 0, 1, 0, 8'h00); expectStatus(8'h01, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h01, 8'h00, 1, 0);
    applyStimulus(8'h00, 1, 0, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);

    $display("[TB] edge coincident with ack-clear");
    issueQ.push_back(3'd6);
    applyStimulus(8'h40, 0, 0, 1, 0, 8'h00); expectStatus(8'h40, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h40, 8'h00, 1, 6);
    issueQ.push_back(3'd6);
    applyStimulus(8'h40, 1, 0, 1, 0, 8'h00); expectStatus(8'h40, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h40, 8'h00, 1, 6);
    applyStimulus(8'h00, 1, 0, 1, 0, 8'h00); expectStatus(8'h00, 8'h00, 0, -1);

    $display("[TB] reset during issue overrides clear, ack and mask write");
    issueQ.push_back(3'd7);
    applyStimulus(8'h80, 0, 0, 1, 0, 8'h00); expectStatus(8'h80, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h80, 8'h00, 1, 7);
    rst_n = 1'b0;
    applyStimulus(8'h00, 1, 1, 1, 1, 8'h00); expectStatus(8'h00, 8'h00, 0, 0);
    rst_n = 1'b1;
    applyStimulus(8'h01, 0, 0, 1, 0, 8'h00); expectStatus(8'h01, 8'h00, 0, -1);
    applyStimulus(8'h01, 0, 0, 1, 0, 8'h00); expectStatus(8'h01, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00); expectStatus(8'h01, 8'h00, 0, -1);
    applyStimulus(8'h00, 0, 0, 1, 0, 8'h00);

    done = 1'b1;
  end

endmodule
